// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one byte-addressed, 32-bit-word unified memory between an
// instruction-fetch port (read-only, i_*) and a data port (read/write, d_*).
// Every access takes exactly three cycles:
//   IDLE : requests sampled, winner latched, address screened
//   ACC  : memory strobe raised (unless the address was rejected)
//   RESP : winner receives a one-cycle ack (qualified by err)
// The arbiter owns the memory strobes; requesters never touch memory directly.
//
// Configuration:
//   MEM_ARB_RR_EN  defined   -> round-robin on a tie (first tie after reset
//                               goes to the data port)
//                  undefined -> fixed priority, data port always wins a tie
//
// Parameters:
//   MEM_SIZE  memory depth in bytes; legal word addresses 0..MEM_SIZE-4
//   ADDR_W    address width
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_req/i_addr        instruction read request and byte address
//   i_rdata/i_ack/i_err instruction response (rdata valid while i_ack)
//   d_req/d_we/d_addr/d_wdata   data request (d_we=1 write)
//   d_rdata/d_ack/d_err data response (rdata valid while d_ack)
//   mem_read/mem_write  memory strobes, only ever high in ACC
//   mem_addr/mem_wrData latched address / write data of the current winner
//   mem_rdData          combinational read data from the memory
//   busy                high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int MEM_SIZE = 3000,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,

  // instruction-fetch port (read-only)
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ack,
  output logic              i_err,

  // data port (read/write)
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_ack,
  output logic              d_err,

  // memory side
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wrData,
  input  logic [31:0]       mem_rdData,

  output logic              busy
);

  // Highest byte address at which a full word still fits in memory.
  localparam logic [ADDR_W-1:0] LAST_WORD_ADDR = ADDR_W'(MEM_SIZE - 4);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state;

  // Latched transaction attributes. The address and write data live directly
  // in mem_addr / mem_wrData, which are visible on the memory bus at all
  // times; only the strobes decide whether memory actually does anything.
  logic sel_d;    // 1 = data port owns the current transaction
  logic lat_we;   // write (always 0 for the instruction port)
  logic lat_err;  // address rejected, no strobe will be raised

`ifdef MEM_ARB_RR_EN
  // Round-robin pointer: 1 when the data port was granted last.
  // Reset value 0 ("instruction last") hands the first tie to the data port.
  logic last_d;
`endif

  // ---------------------------------------------------------------------------
  // Address screening: misaligned or past the last full word.
  // ---------------------------------------------------------------------------
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_WORD_ADDR);
  endfunction

  // ---------------------------------------------------------------------------
  // Arbitration decision and the values the winner would latch. Only
  // consumed in IDLE; evaluated every cycle because it is pure logic.
  // ---------------------------------------------------------------------------
  logic              grant_d;
  logic              gnt_we;
  logic              gnt_err;
  logic [ADDR_W-1:0] gnt_addr;
  logic [31:0]       gnt_wdata;

  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    grant_d = 1'b0;
    if (d_req && i_req) begin
`ifdef MEM_ARB_RR_EN
      grant_d = !last_d;
`else
      grant_d = 1'b1;
`endif
    end else if (d_req) begin
      grant_d = 1'b1;
    end

    gnt_we    = grant_d && d_we;
    gnt_addr  = grant_d ? d_addr  : i_addr;
    gnt_wdata = grant_d ? d_wdata : 32'h0;
    gnt_err   = addr_bad(gnt_addr);
  end

  // ---------------------------------------------------------------------------
  // Sequencer. All outputs are registered so that an asynchronous reset
  // drops the strobes immediately, even in the middle of ACC, and an
  // aborted transaction can never produce an ack.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      sel_d      <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wrData <= 32'h0;
      i_rdata    <= 32'h0;
      i_ack      <= 1'b0;
      i_err      <= 1'b0;
      d_rdata    <= 32'h0;
      d_ack      <= 1'b0;
      d_err      <= 1'b0;
      busy       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_d     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            state      <= ST_ACC;
            busy       <= 1'b1;
            sel_d      <= grant_d;
            lat_we     <= gnt_we;
            lat_err    <= gnt_err;
            mem_addr   <= gnt_addr;
            mem_wrData <= gnt_wdata;
            // Strobes for ACC are decided here so they are glitch-free
            // register outputs for the whole ACC cycle.
            mem_read   <= !gnt_err && !gnt_we;
            mem_write  <= !gnt_err &&  gnt_we;
`ifdef MEM_ARB_RR_EN
            // Updated on every grant, rejected ones included.
            last_d     <= grant_d;
`endif
          end
        end

        ST_ACC: begin
          state     <= ST_RESP;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          // Only the winner's response registers move; the loser's
          // rdata keeps whatever it last returned.
          if (sel_d) begin
            d_rdata <= (lat_we || lat_err) ? 32'h0 : mem_rdData;
            d_ack   <= 1'b1;
            d_err   <= lat_err;
          end else begin
            i_rdata <= lat_err ? 32'h0 : mem_rdData;
            i_ack   <= 1'b1;
            i_err   <= lat_err;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          i_ack <= 1'b0;
          i_err <= 1'b0;
          d_ack <= 1'b0;
          d_err <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
          i_ack     <= 1'b0;
          i_err     <= 1'b0;
          d_ack     <= 1'b0;
          d_err     <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Structural invariants of the sequencer.
  // ---------------------------------------------------------------------------
  a_strobes_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));

  a_strobes_only_in_acc : assert property (@(posedge clk) disable iff (rst)
    (mem_read || mem_write) |-> (state == ST_ACC));

  a_single_completion : assert property (@(posedge clk) disable iff (rst)
    !(i_ack && d_ack));

  a_ack_only_in_resp : assert property (@(posedge clk) disable iff (rst)
    (i_ack || d_ack) |-> (state == ST_RESP));

  a_busy_tracks_state : assert property (@(posedge clk) disable iff (rst)
    busy == (state != ST_IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a behavioural word memory attached to
// the memory port. Inputs are driven and outputs sampled on the falling edge
// of clk, half a cycle away from the rising edge where the DUT updates.
// Tie-order expectations follow MEM_ARB_RR_EN, so the same file serves both
// builds.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int MEM_SIZE  = 3000;
  localparam int ADDR_W    = 32;
  localparam int MEM_WORDS = MEM_SIZE / 4;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ack;
  logic              i_err;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_ack;
  logic              d_err;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wrData;
  logic [31:0]       mem_rdData;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_ack      (i_ack),
    .i_err      (i_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_ack      (d_ack),
    .d_err      (d_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wrData (mem_wrData),
    .mem_rdData (mem_rdData),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural memory: combinational read, write commits on the clk edge.
  // A backdoor port preloads words while the DUT is idle.
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; only words that were
  // preloaded or written are ever read, so unknowns elsewhere are harmless.
  logic [31:0] mem [MEM_WORDS];
  int          ridx;
  logic        bd_we = 1'b0;
  int          bd_idx = 0;
  logic [31:0] bd_val = 32'h0;

  assign ridx       = int'(mem_addr[ADDR_W-1:2]);
  assign mem_rdData = (mem_read && ridx < MEM_WORDS) ? mem[ridx] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && ridx < MEM_WORDS) mem[ridx] <= mem_wrData;
    else if (bd_we)                    mem[bd_idx] <= bd_val;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only). Each issue_* task starts from an IDLE
  // cycle, holds the request for the sampling cycle, drops it, and returns
  // at the falling edge inside the ACC cycle.
  // ---------------------------------------------------------------------------
  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic issue_i(input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    i_req = 1'b1; i_addr = addr;
    @(negedge clk);
    i_req = 1'b0; i_addr = 32'hFFFF_FFFC;
  endtask

  task automatic issue_d(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [31:0] wdata);
    @(negedge clk);
    d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'hFFFF_FFFC; d_wdata = 32'h5A5A_5A5A;
  endtask

  task automatic reset_dut();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    checks++; if (mem_read !== 1'b0)    begin errors++; $display("FAIL rst_mem_read got=%0h exp=0", mem_read); end
    checks++; if (mem_write !== 1'b0)   begin errors++; $display("FAIL rst_mem_write got=%0h exp=0", mem_write); end
    checks++; if ({i_ack, i_err, d_ack, d_err} !== 4'b0) begin errors++; $display("FAIL rst_ack_err got=%b exp=0000", {i_ack, i_err, d_ack, d_err}); end
    checks++; if (mem_addr !== 32'h0)   begin errors++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
    checks++; if (mem_wrData !== 32'h0) begin errors++; $display("FAIL rst_mem_wrData got=%0h exp=0", mem_wrData); end
    checks++; if (i_rdata !== 32'h0)    begin errors++; $display("FAIL rst_i_rdata got=%0h exp=0", i_rdata); end
    checks++; if (d_rdata !== 32'h0)    begin errors++; $display("FAIL rst_d_rdata got=%0h exp=0", d_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_ifetch();
    preload(2, 32'd3);
    preload(749, 32'hCAFE_F00D);
    preload(1, 32'h1111_1111);
    issue_i(32'd8);
    // ACC
    checks++; if (mem_read !== 1'b1)  begin errors++; $display("FAIL if_acc_read got=%0h exp=1", mem_read); end
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL if_acc_write got=%0h exp=0", mem_write); end
    checks++; if (mem_addr !== 32'd8) begin errors++; $display("FAIL if_acc_addr got=%0h exp=8", mem_addr); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL if_acc_busy got=%0h exp=1", busy); end
    checks++; if (i_ack !== 1'b0)     begin errors++; $display("FAIL if_acc_early_ack got=%0h exp=0", i_ack); end
    @(negedge clk); // RESP
    checks++; if (i_ack !== 1'b1)     begin errors++; $display("FAIL if_resp_ack got=%0h exp=1", i_ack); end
    checks++; if (i_rdata !== 32'd3)  begin errors++; $display("FAIL if_resp_rdata got=%0h exp=3", i_rdata); end
    checks++; if (i_err !== 1'b0)     begin errors++; $display("FAIL if_resp_err got=%0h exp=0", i_err); end
    checks++; if (d_ack !== 1'b0)     begin errors++; $display("FAIL if_resp_d_ack got=%0h exp=0", d_ack); end
    checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL if_resp_busy got=%0h exp=1", busy); end
    checks++; if (mem_read !== 1'b0)  begin errors++; $display("FAIL if_resp_read got=%0h exp=0", mem_read); end
    @(negedge clk); // IDLE
    checks++; if (i_ack !== 1'b0)     begin errors++; $display("FAIL if_idle_ack got=%0h exp=0", i_ack); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL if_idle_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_write_read();
    issue_d(1'b1, 32'd48, 32'hDEAD_BEEF);
    checks++; if (mem_write !== 1'b1)          begin errors++; $display("FAIL wr_acc_write got=%0h exp=1", mem_write); end
    checks++; if (mem_read !== 1'b0)           begin errors++; $display("FAIL wr_acc_read got=%0h exp=0", mem_read); end
    checks++; if (mem_wrData !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_acc_wdata got=%0h exp=deadbeef", mem_wrData); end
    @(negedge clk); // RESP
    checks++; if (mem_write !== 1'b0)          begin errors++; $display("FAIL wr_resp_write got=%0h exp=0", mem_write); end
    checks++; if (d_ack !== 1'b1 || d_err !== 1'b0) begin errors++; $display("FAIL wr_resp_ack_err got=%b exp=10", {d_ack, d_err}); end
    checks++; if (d_rdata !== 32'h0)           begin errors++; $display("FAIL wr_resp_rdata got=%0h exp=0", d_rdata); end
    checks++; if (mem[12] !== 32'hDEADBEEF)    begin errors++; $display("FAIL wr_committed got=%0h exp=deadbeef", mem[12]); end
    // back-to-back: read issued in the very next IDLE
    issue_d(1'b0, 32'd48, 32'h0);
    checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0) begin errors++; $display("FAIL rd_acc_strobes got=%b exp=10", {mem_read, mem_write}); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1)              begin errors++; $display("FAIL rd_resp_ack got=%0h exp=1", d_ack); end
    checks++; if (d_rdata !== 32'hDEADBEEF)    begin errors++; $display("FAIL rd_resp_rdata got=%0h exp=deadbeef", d_rdata); end
    checks++; if (i_rdata !== 32'd3)           begin errors++; $display("FAIL rd_loser_rdata got=%0h exp=3", i_rdata); end
  endtask

  task automatic test_tie();
    logic [3:0] exp_d;
`ifdef MEM_ARB_RR_EN
    exp_d = 4'b0101;  // bit k = transaction k: D, I, D, I
`else
    exp_d = 4'b1111;  // D, D, D, D
`endif
    reset_dut();
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'd8;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'd48;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); // ACC
      @(negedge clk); // RESP
      checks++;
      if (d_ack !== exp_d[k] || i_ack !== !exp_d[k]) begin
        errors++; $display("FAIL tie_grant_%0d got d_ack=%0h i_ack=%0h exp d_ack=%0h", k, d_ack, i_ack, exp_d[k]);
      end
      checks++;
      if (exp_d[k] ? (d_rdata !== 32'hDEADBEEF) : (i_rdata !== 32'd3)) begin
        errors++; $display("FAIL tie_rdata_%0d got d=%0h i=%0h", k, d_rdata, i_rdata);
      end
      if (k == 3) begin
        i_req = 1'b0; d_req = 1'b0;
      end
      @(negedge clk); // IDLE
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tie_final_busy got=%0h exp=0", busy); end
  endtask

  task automatic test_wait();
    issue_d(1'b0, 32'd48, 32'h0);
    // i_req arrives during ACC and must be held until served
    i_req = 1'b1; i_addr = 32'd2996;
    @(negedge clk); // RESP of data read
    checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("FAIL wait_first got d_ack=%0h i_ack=%0h exp 1 0", d_ack, i_ack); end
    @(negedge clk); // IDLE, i_req sampled at next edge
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wait_idle_busy got=%0h exp=0", busy); end
    @(negedge clk); // ACC of instruction read
    i_req = 1'b0;
    checks++; if (mem_read !== 1'b1 || mem_addr !== 32'd2996) begin errors++; $display("FAIL wait_acc got read=%0h addr=%0d exp 1 2996", mem_read, mem_addr); end
    @(negedge clk);
    checks++; if (i_ack !== 1'b1 || i_err !== 1'b0) begin errors++; $display("FAIL wait_ack_err got=%b exp=10", {i_ack, i_err}); end
    checks++; if (i_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL last_word_rdata got=%0h exp=cafef00d", i_rdata); end
  endtask

  task automatic test_errors();
    // misaligned data write
    issue_d(1'b1, 32'd6, 32'h7777_7777);
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL err_d_strobes got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (mem_addr !== 32'd6) begin errors++; $display("FAIL err_d_addr_shown got=%0d exp=6", mem_addr); end
    @(negedge clk);
    checks++; if ({d_ack, d_err} !== 2'b11) begin errors++; $display("FAIL err_d_ack_err got=%b exp=11", {d_ack, d_err}); end
    checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL err_d_rdata got=%0h exp=0", d_rdata); end
    checks++; if (mem[1] !== 32'h1111_1111) begin errors++; $display("FAIL err_d_no_commit got=%0h exp=11111111", mem[1]); end
    // misaligned and out of range instruction read
    issue_i(32'd2998);
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin errors++; $display("FAIL err_i_strobes got=%b exp=00", {mem_read, mem_write}); end
    @(negedge clk);
    checks++; if ({i_ack, i_err} !== 2'b11) begin errors++; $display("FAIL err_i_ack_err got=%b exp=11", {i_ack, i_err}); end
    checks++; if (i_rdata !== 32'h0) begin errors++; $display("FAIL err_i_rdata got=%0h exp=0", i_rdata); end
    // aligned but one word past the end
    issue_i(32'd3000);
    checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL err_range_read got=%0h exp=0", mem_read); end
    @(negedge clk);
    checks++; if ({i_ack, i_err} !== 2'b11) begin errors++; $display("FAIL err_range_ack_err got=%b exp=11", {i_ack, i_err}); end
  endtask

  task automatic test_reset_mid();
    issue_d(1'b1, 32'd48, 32'h1234_5678);
    checks++; if (mem_write !== 1'b1) begin errors++; $display("FAIL rmid_acc_write got=%0h exp=1", mem_write); end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_write !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL rmid_strobes_drop got=%b exp=00", {mem_read, mem_write}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0h exp=0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (d_ack !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_no_ack_%0d got ack=%0h busy=%0h exp 0 0", c, d_ack, busy); end
    end
    checks++; if (mem[12] !== 32'hDEADBEEF) begin errors++; $display("FAIL rmid_mem_unchanged got=%0h exp=deadbeef", mem[12]); end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 32'h0;
    test_reset();
    test_ifetch();
    test_write_read();
    test_tie();
    test_wait();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Shares the single byte-addressed, 32-bit-word unified memory between two requesters: the instruction-fetch port (read-only, `i_`) and the data port (`d_`, read/write).
- Owns the memory control strobes, so neither requester drives the memory directly.
- Sequences every access through a fixed 3-cycle grant/access/response FSM.
- Screens addresses for alignment and range before any memory strobe is raised.

## Interface
Parameters:
- MEM_SIZE, 3000: memory depth in bytes; legal word addresses are 0..MEM_SIZE-4.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction-port read request.
- i_addr  in  ADDR_W  instruction byte address.
- i_rdata  out  32  instruction read data, valid while i_ack=1.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  qualifies i_ack: access rejected.
- d_req  in  1  data-port request.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data byte address.
- d_wdata  in  32  write data.
- d_rdata  out  32  read data, valid while d_ack=1.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  qualifies d_ack.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe; the memory commits on the clk edge.
- mem_addr  out  ADDR_W  memory byte address.
- mem_wrData  out  32  memory write data.
- mem_rdData  in  32  memory read data; combinational from mem_addr and mem_read.
- busy  out  1  1 whenever the FSM is not in IDLE.

## Operation
FSM states and transitions:
- IDLE -> ACC when any request is present; otherwise stay in IDLE.
- ACC -> RESP unconditionally.
- RESP -> IDLE unconditionally.

Arbitration (in IDLE only):
- Pick the winner from i_req and d_req.
- Latch the winner's port id, we (forced to 0 for the instruction port), addr and wdata into internal registers.
- Latch the error flag: err = (addr[1:0]!=0) or (addr > MEM_SIZE-4).

ACC state:
- mem_addr and mem_wrData are driven from the latched registers.
- If not err: mem_read = !we and mem_write = we.
- If err: both strobes stay 0.
- At the closing edge of ACC, capture mem_rdData into the winner's rdata register. Capture 0 for a write or for err.

RESP state:
- Assert the winner's ack for exactly one cycle; assert its err if latched.
- The losing port's ack and err stay 0.

Register and output behaviour:
- Requests are sampled only in IDLE.
- The address/data latches hold their value in every state except IDLE-with-grant.
- mem_addr and mem_wrData show the latched values in all states; only the strobes gate memory activity.
- Exactly one port completes per transaction.
- The loser keeps its request high and is arbitrated again in the next IDLE.

## Timing
Latency:
- Request sampled in cycle N (IDLE).
- Strobes active in cycle N+1 (ACC); a write commits at the end of N+1.
- ack in cycle N+2 (RESP).
- Next sampling in cycle N+3.
- Maximum throughput: one access per 3 cycles.

Requester rules:
- Inputs need to be stable only in the sampling cycle, because they are latched at grant.
- req still high in N+3 is treated as a new request.

Other timing rules:
- A request arriving during ACC or RESP waits; it is not lost as long as the requester holds req.
- Strobes are 0 in IDLE and RESP, so there is never a spurious write.

Reset values (rst=1, asynchronous):
- State = IDLE.
- All strobes, acks, errs and busy = 0.
- rdata registers, mem_addr and mem_wrData = 0.
- Round-robin pointer = "instruction last".

Reset mid-operation:
- Reset during ACC drops the strobes immediately; a write in progress does not commit unless the clk edge precedes reset assertion.
- No ack is produced for an aborted transaction.

## Configuration
- Macro: `MEM_ARB_RR_EN`.
- Defined: round-robin arbitration. On a tie, the port not granted last wins. The pointer updates on every grant, including err grants. The first tie after reset goes to the data port.
- Undefined: fixed priority, data over instruction, on every tie. The pointer logic is absent. An instruction request can starve while d_req stays high.

## Test plan
- Instruction read: memory word 8 = 3, i_req with i_addr=8 in cycle 0. Expect mem_read=1 and mem_addr=8 in cycle 1, then i_ack=1, i_rdata=3, i_err=0 in cycle 2, with busy=1 in cycles 1-2.
- Data write then read: d_we=1, d_addr=48, d_wdata=0xDEADBEEF, followed by a d_we=0 read of 48. Expect mem_write for exactly one cycle, then d_rdata=0xDEADBEEF on the second d_ack.
- Tie: i_req and d_req both held for 4 transactions. Without the macro: grant order D,D,D,D. With `MEM_ARB_RR_EN`: D,I,D,I.
- Errors: a d_addr=6 write and an i_addr=2998 read. Expect err=1 with ack in cycle 2, rdata=0, and mem_read and mem_write never asserted.
- Reset mid-access: rst asserted asynchronously in the ACC cycle of a write to 48. Expect strobes to drop at once, no d_ack, IDLE after reset, and memory word 48 unchanged.
